// File: rtl/rv32i_regfile_tb_checker_if.sv
// Snoop bus between the register-file stimulus driver and its checker.
// Carries the write strobe, the read request and its one-cycle-late data,
// and the PC sample stream.
//   master : driver side, sources every signal
//   slave  : checker side, observes every signal
interface rv32i_regfile_tb_checker_if #(
    parameter int XLEN = 32
);
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            rd_valid;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            pc_valid;
    logic [XLEN-1:0] pc_out;

    modport master (
        output wr_en, wr_addr, wr_data, rd_valid, rs1_addr, rs2_addr,
               rs1_data, rs2_data, pc_valid, pc_out
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_valid, rs1_addr, rs2_addr,
               rs1_data, rs2_data, pc_valid, pc_out
    );
endinterface

// File: rtl/rv32i_regfile_tb_checker.sv
// Register-file response checker.
// Keeps a shadow copy of the architectural registers from snooped writes,
// predicts rs1/rs2 read data one cycle ahead, checks the PC stride, and
// accumulates saturating pass/error counts plus a frozen first-error record.
//   clk, rst (async, active-low), chk_en : control
//   bus (slave)                           : snooped driver traffic
//   pass_count, err_count                 : saturating comparison counters
//   err_flag, first_err_*                 : sticky capture of the first mismatch
//   busy                                  : FSM in SEED or CHECK

// One read port: latches the predicted value and index on launch.
module rv32i_regfile_tb_checker_port #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               launch,
    input  logic [4:0]                         rd_addr,
    input  logic                               wr_en,
    input  logic [4:0]                         wr_addr,
    input  logic [XLEN-1:0]                    wr_data,
    input  logic [NUM_REGS-1:0][XLEN-1:0]      shadow,
    output logic [XLEN-1:0]                    exp_q,
    output logic [4:0]                         addr_q
);
    logic [XLEN-1:0] exp_d;

    always_comb begin
        exp_d = '0;
        if (rd_addr == 5'd0 || int'(rd_addr) >= NUM_REGS)
            exp_d = '0;
        else if (BYPASS && wr_en && wr_addr == rd_addr)
            exp_d = wr_data;  // same-cycle write is visible to the read
        else
            exp_d = shadow[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q  <= '0;
            addr_q <= '0;
        end else if (launch) begin
            exp_q  <= exp_d;
            addr_q <= rd_addr;
        end
    end
endmodule

module rv32i_regfile_tb_checker #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int PC_STEP  = 4,
    parameter bit BYPASS   = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chk_en,
    rv32i_regfile_tb_checker_if.slave bus,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 err_flag,
    output logic [1:0]           first_err_kind,
    output logic [4:0]           first_err_addr,
    output logic [XLEN-1:0]      first_err_exp,
    output logic [XLEN-1:0]      first_err_act,
    output logic                 busy
);
    localparam int STAGES = 1;
    localparam int NPORT  = 2;

    typedef enum logic [1:0] {S_IDLE, S_SEED, S_CHECK} state_t;
    state_t state, state_nxt;

    logic [NUM_REGS-1:0][XLEN-1:0] shadow;
    logic [STAGES:0]               vld_pipe;
    logic [NPORT-1:0][4:0]         rd_addr, addr_q;
    logic [NPORT-1:0][XLEN-1:0]    rd_data, exp_q;
    logic [NPORT-1:0]              rd_hit, rd_miss;
    logic [XLEN-1:0]               last_pc, pc_exp;
    logic                          active, fire, pc_hit, pc_miss;
    logic [1:0]                    pass_inc, err_inc;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (chk_en) state_nxt = S_SEED;
            S_SEED:  if (!chk_en) state_nxt = S_IDLE;
                     else if (bus.pc_valid) state_nxt = S_CHECK;
            S_CHECK: if (!chk_en) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Compares run only while CHECK is held; dropping chk_en also
    // suppresses a read compare already in flight.
    assign active = (state == S_CHECK) && chk_en;
    assign busy   = (state != S_IDLE);

    // ---------------- shadow registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            shadow <= '0;
        else if (bus.wr_en && bus.wr_addr != 5'd0 && int'(bus.wr_addr) < NUM_REGS)
            shadow[bus.wr_addr] <= bus.wr_data;
    end

    // ---------------- read pipeline ----------------
    assign vld_pipe[0] = bus.rd_valid && active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_pipe[STAGES:1] <= '0;
        else      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    assign fire       = vld_pipe[STAGES] && active;
    assign rd_addr[0] = bus.rs1_addr;
    assign rd_addr[1] = bus.rs2_addr;
    assign rd_data[0] = bus.rs1_data;
    assign rd_data[1] = bus.rs2_data;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        rv32i_regfile_tb_checker_port #(
            .XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS)
        ) u_port (
            .clk    (clk),
            .rst    (rst),
            .launch (vld_pipe[0]),
            .rd_addr(rd_addr[p]),
            .wr_en  (bus.wr_en),
            .wr_addr(bus.wr_addr),
            .wr_data(bus.wr_data),
            .shadow (shadow),
            .exp_q  (exp_q[p]),
            .addr_q (addr_q[p])
        );
        assign rd_hit[p]  = fire && (rd_data[p] == exp_q[p]);
        assign rd_miss[p] = fire && (rd_data[p] != exp_q[p]);
    end

    // ---------------- PC stride ----------------
    assign pc_exp  = last_pc + XLEN'(PC_STEP);  // wraps modulo 2^XLEN
    assign pc_hit  = active && bus.pc_valid && (bus.pc_out == pc_exp);
    assign pc_miss = active && bus.pc_valid && (bus.pc_out != pc_exp);

    // Track the actual PC so a single bad beat flags once, not forever.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_pc <= '0;
        else if (bus.pc_valid && chk_en && (state == S_SEED || state == S_CHECK))
            last_pc <= bus.pc_out;
    end

    // ---------------- counters ----------------
    assign pass_inc = {1'b0, rd_hit[0]} + {1'b0, rd_hit[1]} + {1'b0, pc_hit};
    assign err_inc  = {1'b0, rd_miss[0]} + {1'b0, rd_miss[1]} + {1'b0, pc_miss};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0] inc);
        logic [CNT_W+1:0] s;
        s = {2'b00, c} + (CNT_W+2)'(inc);
        return (s > (CNT_W+2)'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_count <= '0;
            err_count  <= '0;
        end else begin
            pass_count <= sat_add(pass_count, pass_inc);
            err_count  <= sat_add(err_count, err_inc);
        end
    end

    // ---------------- first-error capture ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag       <= 1'b0;
            first_err_kind <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else if (!err_flag && (|rd_miss || pc_miss)) begin
            err_flag <= 1'b1;
            if (rd_miss[0]) begin
                first_err_kind <= 2'b01;
                first_err_addr <= addr_q[0];
                first_err_exp  <= exp_q[0];
                first_err_act  <= rd_data[0];
            end else if (rd_miss[1]) begin
                first_err_kind <= 2'b10;
                first_err_addr <= addr_q[1];
                first_err_exp  <= exp_q[1];
                first_err_act  <= rd_data[1];
            end else begin
                first_err_kind <= 2'b11;
                first_err_addr <= 5'd0;
                first_err_exp  <= pc_exp;
                first_err_act  <= bus.pc_out;
            end
        end
    end
endmodule

// File: doc/rv32i_regfile_tb_checker.md
Name: rv32i_regfile_tb_checker

Overview:
Response-side checker paired with the register-file stimulus driver in the processor bench. It snoops every register-file write and read request, keeps a shadow copy of the architectural registers, and compares returned rs1/rs2 read data and the PC stream against expected values. It accumulates pass/error counts and captures the first failure. It is synthesizable so it can also run on the Nexys 4 DDR as a hardware self-check.

Parameters:
XLEN, 32, datapath width; must equal `MAX_XLEN_INDEX+1.
NUM_REGS, 32, architectural register count; x0 is hardwired to zero.
PC_STEP, 4, required PC increment per pc_valid beat.
BYPASS, 1, 1 = read issued in the same cycle as a write to the same register expects the new data; 0 = expects the old data.
CNT_W, 16, width of pass/error counters.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
chk_en  in  1  enables checking; low returns the FSM to IDLE
wr_en  in  1  register-file write strobe
wr_addr  in  5  write register index
wr_data  in  XLEN  write data
rd_valid  in  1  read request strobe
rs1_addr  in  5  read port 1 index
rs2_addr  in  5  read port 2 index
rs1_data  in  XLEN  port 1 data, valid one cycle after rd_valid
rs2_data  in  XLEN  port 2 data, valid one cycle after rd_valid
pc_valid  in  1  pc_out sample strobe
pc_out  in  XLEN  driver PC value
pass_count  out  CNT_W  count of read/PC comparisons that matched
err_count  out  CNT_W  count of mismatches
err_flag  out  1  sticky, set on the first mismatch
first_err_kind  out  2  01 = rs1, 10 = rs2, 11 = PC
first_err_addr  out  5  register index of the first error (0 for a PC error)
first_err_exp  out  XLEN  expected value at the first error
first_err_act  out  XLEN  actual value at the first error
busy  out  1  high in the SEED or CHECK state

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, shadow registers all 0, FSM in IDLE, pipeline valid bit 0.
- FSM states:
  - IDLE: no checks. Shadow still tracks writes. Counters and first-error capture hold their values. chk_en=1 moves to SEED next cycle.
  - SEED: the first pc_valid captures pc_out as the baseline (no compare). Then go to CHECK.
  - CHECK: all compares are active.
  - From SEED or CHECK, chk_en=0 returns to IDLE next cycle and discards any pending read compare.
- Shadow write:
  - wr_en with wr_addr != 0 updates shadow[wr_addr] at the clock edge.
  - Writes to x0 are ignored.
  - Shadow updates in every state.
- Read check, one-cycle latency:
  - Cycle N: on rd_valid in CHECK, latch the expected values for both ports.
  - Expected value is 0 for address 0. If BYPASS=1 and wr_en && wr_addr==addr (addr != 0), expected is wr_data. Otherwise expected is shadow[addr].
  - Cycle N+1: compare rs1_data and rs2_data against the latched values. Each port is one comparison.
  - Back-to-back rd_valid every cycle is supported with no bubbles.
- PC check (CHECK only): on pc_valid, expected = last_pc + PC_STEP, modulo 2^XLEN (wrap from 0xFFFFFFFC to 0x00000000 is legal). last_pc updates to the actual pc_out, so one error does not cascade.
- Counting:
  - Each match adds 1 to pass_count; each mismatch adds 1 to err_count.
  - Up to 3 comparisons can complete in one cycle (rs1, rs2, PC). Sum them in that cycle.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- First error:
  - On the first mismatch, set err_flag and load the first_err_* fields.
  - Priority within a cycle: rs1, then rs2, then PC.
  - The capture is frozen until reset. chk_en toggling does not clear it.
- Reset mid-operation clears the pending compare and the shadow; no compare fires after reset releases until a new rd_valid is seen in CHECK.

Test Plan:
- Reset, chk_en=1, one pc_valid with pc=0x0, then pc 0x4, 0x8, 0xC → pass_count=3, err_count=0, err_flag=0.
- Write x5=0xDEADBEEF; next cycle rd_valid rs1=5, rs2=0; drive rs1_data=0xDEADBEEF, rs2_data=0 → pass_count +2, no error.
- Write x0=0x1234 then read x0 with rs1_data=0x1234 → err_count=1, first_err_kind=01, addr=0, exp=0, act=0x1234.
- With BYPASS=1, write x7=0xA5A5A5A5 in the same cycle as a read of x7 returning 0xA5A5A5A5 → pass; rerun with BYPASS=0 → mismatch, exp=0.
- Seed pc=0xFFFFFFFC, then pc=0x0 → pass; then pc=0x8 → err_count=1, kind=11, exp=0x4, act=0x8.
- Same-cycle rs1 and rs2 mismatch → err_count +2, first_err_kind=01; assert rst low mid-stream → all outputs 0 immediately, asynchronously.
